tdl_thermo_encoder: RTL
=======================

// Module: tdl_thermo_encoder
// PURPOSE
//  Downstream consumer of the tapped-delay-line snapshot: takes the registered TAPS-wide thermometer
//  word sampled from the AND2/FD chain every clk and detects a hit.
//  On a hit it encodes the fine position and tags it with a free-running coarse count.
//  Emits one {coarse,fine} timestamp per hit over a valid/ready interface toward the readout FIFO.
// PARAMETERS
//  TAPS      4    width of the delay-line snapshot (tap 0 = first element of the chain)
//  COARSE_W  16   coarse counter width; wraps modulo 2^COARSE_W
//  HOLDOFF   2    dead-time cycles after a hit before re-arm search begins (>=1)
//  FINE_W    $clog2(TAPS+1)  derived localparam, not overridable
// PORTS
//  clk        in   1                  sampling clock, same clock as the delay-line flops
//  rst_n      in   1                  synchronous reset, active low
//  en         in   1                  delay-line enable, same signal driving the AND chain
//  taps       in   TAPS               thermometer snapshot from the delay-line flops
//  ts_data    out  COARSE_W+FINE_W    timestamp {coarse, fine}
//  ts_valid   out  1                  timestamp pending
//  ts_ready   in   1                  consumer accepts when ts_valid && ts_ready
//  ovf        out  1                  sticky: a hit was dropped because output was occupied
//  ovf_clr    in   1                  clears ovf (set wins if same cycle)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): tap_q=0, coarse=0, state=WAIT_CLEAR, hold_cnt=0,
//    ts_data=0, ts_valid=0, ovf=0.
//  - tap_q <= taps every cycle (one retiming stage; no other input logic).
//  - coarse increments by 1 every cycle en=1, holds when en=0, wraps 2^COARSE_W-1 -> 0.
//  - FSM:
//    WAIT_CLEAR: -> ARMED when en=1 && tap_q==0
//    ARMED: en=0 -> WAIT_CLEAR; else if tap_q[0]=1 -> hit, -> HOLD with hold_cnt=HOLDOFF-1
//    HOLD: hold_cnt decrements each cycle; at 0 -> WAIT_CLEAR
//    HOLD ignores en; en=0 during WAIT_CLEAR keeps it there
//  - Hit in cycle c (FSM in ARMED, tap_q[0]=1, en=1):
//    ts_data <= {coarse value in cycle c, fine(tap_q)}, ts_valid <= 1 at end of c.
//  - Latency: taps[0] rising on the input in cycle t -> ts_valid=1 in cycle t+2.
//  - Output register: ts_valid clears on handshake.
//    A hit in the same cycle as the handshake loads new data; ts_valid stays 1 with no bubble.
//  - Hit while ts_valid=1 && ts_ready=0: hit dropped, ts_data unchanged, ovf <= 1.
//    FSM still goes to HOLD.
//  - ovf_clr=1 with no concurrent drop -> ovf <= 0.
//  - en=0 does not clear a pending timestamp; the consumer can still drain it.
//  - rst_n=0 mid-HOLD or with a pending timestamp: everything returns to reset values;
//    the pending timestamp is lost.
//  - fine range 0..TAPS; all-ones snapshot gives fine=TAPS (signal ran past the whole line).
// CONFIGURATION
//  TDL_BUBBLE_FIX_EN defined:
//    fine = popcount(tap_q); bubble tolerant, still within the same single cycle.
//  TDL_BUBBLE_FIX_EN undefined:
//    fine = number of contiguous ones from tap_q[0] upward; first zero terminates the count.
// TESTING
//  T1 reset: hold rst_n=0 3 cycles with taps=4'hF, en=1
//     -> ts_valid=0, ovf=0, ts_data=0, coarse restarts at 0 after release.
//  T2 basic hit: en=1, taps=0 until coarse=10, then taps=4'b0111 one cycle, ts_ready=1
//     -> ts_valid 2 cycles later, ts_data={16'd11,3'd3}.
//  T3 bubble: taps=4'b1011 hit
//     -> fine=2 without TDL_BUBBLE_FIX_EN, fine=3 with it.
//  T4 overflow: ts_ready=0, two hits separated by HOLDOFF+2 clear cycles
//     -> first timestamp kept, ovf=1.
//     Then ts_ready=1 and ovf_clr=1 -> drain, ovf=0.
//  T5 re-arm: taps held 4'hF for 10 cycles after a hit -> exactly one timestamp.
//     Taps then 0 and a new hit -> second timestamp.
//  T6 wrap/en: COARSE_W=4, en low 3 cycles at coarse=14 (no increment, no hit accepted),
//     then hit when coarse=0 after wrap -> ts_data coarse field = 0.

Source files
------------

// File: rtl/tdl_thermo_encoder.sv
// -----------------------------------------------------------------------------
// tdl_thermo_encoder
//
// Consumes the registered thermometer snapshot of a tapped delay line and
// detects a hit. Each hit produces one {coarse, fine} timestamp on a
// valid/ready interface toward the readout FIFO.
//   - coarse: free-running counter that advances while en=1
//   - fine  : position of the signal edge inside the delay line (0..TAPS)
//
// Configuration macro:
//   TDL_BUBBLE_FIX_EN  defined   -> fine = popcount of the snapshot (bubble tolerant)
//                      undefined -> fine = run of ones from tap 0 upward
//
// Ports:
//   clk       in   sampling clock, same clock as the delay-line flops
//   rst_n     in   synchronous reset, active low
//   en        in   delay-line enable (same signal as the AND chain enable)
//   taps      in   TAPS-wide thermometer snapshot, tap 0 = first chain element
//   ts_data   out  {coarse, fine} timestamp
//   ts_valid  out  timestamp pending
//   ts_ready  in   consumer accepts when ts_valid && ts_ready
//   ovf       out  sticky: a hit was dropped because the output was occupied
//   ovf_clr   in   clears ovf; a drop in the same cycle wins
// -----------------------------------------------------------------------------
module tdl_thermo_encoder #(
    parameter  int TAPS     = 4,
    parameter  int COARSE_W = 16,
    parameter  int HOLDOFF  = 2,
    localparam int FINE_W   = $clog2(TAPS + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [TAPS-1:0]            taps,
    output logic [COARSE_W+FINE_W-1:0] ts_data,
    output logic                       ts_valid,
    input  logic                       ts_ready,
    output logic                       ovf,
    input  logic                       ovf_clr
);

    // Hold counter only needs to represent 0..HOLDOFF-1; keep at least one bit.
    localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {
        WAIT_CLEAR = 2'd0,
        ARMED      = 2'd1,
        HOLD       = 2'd2
    } state_t;

    logic [TAPS-1:0]            r_tap_q;
    logic [COARSE_W-1:0]        r_coarse;
    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [HC_W-1:0]            r_hold_cnt;
    logic [HC_W-1:0]            w_hold_cnt_nxt;
    logic                       w_hit;
    logic [FINE_W-1:0]          w_fine;
    logic                       w_load;
    logic                       w_drop;
    logic                       w_accept;
    logic [COARSE_W+FINE_W-1:0] r_ts_data;
    logic                       r_ts_valid;
    logic                       r_ovf;

    // -------------------------------------------------------------------------
    // Retiming stage and coarse counter
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tap_q  <= '0;
            r_coarse <= '0;
        end else begin
            r_tap_q <= taps;
            if (en) begin
                r_coarse <= r_coarse + COARSE_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Fine position encoder (single cycle, purely combinational on r_tap_q)
    // -------------------------------------------------------------------------
`ifdef TDL_BUBBLE_FIX_EN
    // Popcount: an isolated zero inside the run still counts the ones above it.
    always_comb begin
        w_fine = '0;
        for (int i = 0; i < TAPS; i++) begin
            w_fine = w_fine + FINE_W'(r_tap_q[i]);
        end
    end
`else
    logic w_run;

    // Length of the unbroken run of ones starting at tap 0.
    always_comb begin
        w_fine = '0;
        w_run  = 1'b1;
        for (int i = 0; i < TAPS; i++) begin
            if (w_run && r_tap_q[i]) begin
                w_fine = w_fine + FINE_W'(1);
            end else begin
                w_run = 1'b0;
            end
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Hit-detection FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= WAIT_CLEAR;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_hit          = 1'b0;
        case (r_state)
            // Re-arm only once the line has fully drained.
            WAIT_CLEAR: begin
                if (en && (r_tap_q == '0)) begin
                    w_state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (!en) begin
                    w_state_nxt = WAIT_CLEAR;
                end else if (r_tap_q[0]) begin
                    w_hit          = 1'b1;
                    w_state_nxt    = HOLD;
                    w_hold_cnt_nxt = HC_W'(HOLDOFF - 1);
                end
            end
            // Dead time ignores en; it runs for exactly HOLDOFF cycles.
            HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_state_nxt = WAIT_CLEAR;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - HC_W'(1);
                end
            end
            default: begin
                w_state_nxt = WAIT_CLEAR;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output register: single-entry slot with overflow flag
    // -------------------------------------------------------------------------
    assign w_accept = r_ts_valid && ts_ready;
    // A hit may reuse the slot in the very cycle it is being drained.
    assign w_load   = w_hit && (!r_ts_valid || ts_ready);
    assign w_drop   = w_hit && r_ts_valid && !ts_ready;

    // NOTE: the timestamp register is reset along with valid, so a pending
    // timestamp is discarded and ts_data reads zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ts_data  <= '0;
            r_ts_valid <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_load) begin
                r_ts_data  <= {r_coarse, w_fine};
                r_ts_valid <= 1'b1;
            end else if (w_accept) begin
                r_ts_valid <= 1'b0;
            end

            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign ts_data  = r_ts_data;
    assign ts_valid = r_ts_valid;
    assign ovf      = r_ovf;

endmodule
